// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V pipeline hazard controller.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } hz_state_e;

endpackage

// File: rtl/riscv_fwd_unit.sv
// Forwarding select for one E-stage source operand.
module riscv_fwd_unit
    import riscv_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs_i,
    input  logic [AW-1:0] rd_m_i,
    input  logic          reg_write_m_i,
    input  logic [AW-1:0] rd_w_i,
    input  logic          reg_write_w_i,
    output fwd_sel_e      sel_o
);

    logic rs_nz;
    logic hit_m;
    logic hit_w;

    assign rs_nz = |rs_i;
    assign hit_m = reg_write_m_i && (rd_m_i == rs_i) && rs_nz;
    assign hit_w = reg_write_w_i && (rd_w_i == rs_i) && rs_nz;

    // M holds the younger result, so it wins over W.
    always_comb begin
        sel_o = FWD_RF;
        priority case (1'b1)
            hit_m:   sel_o = FWD_M;
            hit_w:   sel_o = FWD_W;
            default: sel_o = FWD_RF;
        endcase
    end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Hazard controller: forwarding, load-use/branch control, memory wait FSM.
// Optional perf counters enabled with HAZ_PERF_CNT_EN.
module riscv_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int REG_ADDR_W  = riscv_pkg::REG_ADDR_W,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  ResultSrcE0,
    input  logic                  PCSrcE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic                  RegWriteM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteW,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]           PerfMemStall,
    output logic [31:0]           PerfLoadUse,
    output logic [31:0]           PerfFlush,
`endif
    output logic                  MemErr
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;
    logic     lw_stall;
    logic     mem_stall;
    logic     mem_miss;
    logic     in_err;

    riscv_fwd_unit #(.AW(REG_ADDR_W)) u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_a)
    );

    riscv_fwd_unit #(.AW(REG_ADDR_W)) u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_b)
    );

    assign in_err    = (state_q == ERR);
    assign mem_miss  = MemReqM && !MemReadyM;
    assign mem_stall = in_err || mem_miss;
    assign lw_stall  = ResultSrcE0 && (|RdE) &&
                       ((Rs1D == RdE) || (Rs2D == RdE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (mem_miss) begin
                    state_d = MEM_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM || !MemReqM) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= (state_d == ERR);
        end
    end

    // Reset dominates so the pipeline fills with bubbles while held.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        priority case (1'b1)
            reset: begin
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushW = 1'b1;
            end
            mem_stall: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end
            default: begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushE = lw_stall || PCSrcE;
                FlushD = PCSrcE;
            end
        endcase
    end

    assign ForwardAE = reset ? FWD_RF : fwd_a;
    assign ForwardBE = reset ? FWD_RF : fwd_b;
    assign MemErr    = err_q && !reset;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_ms_q, perf_lu_q, perf_fl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ms_q <= '0;
            perf_lu_q <= '0;
            perf_fl_q <= '0;
        end else begin
            if (mem_stall)
                perf_ms_q <= perf_ms_q + 32'd1;
            if (lw_stall && !mem_stall)
                perf_lu_q <= perf_lu_q + 32'd1;
            if (PCSrcE && !mem_stall)
                perf_fl_q <= perf_fl_q + 32'd1;
        end
    end

    assign PerfMemStall = perf_ms_q;
    assign PerfLoadUse  = perf_lu_q;
    assign PerfFlush    = perf_fl_q;
`endif

endmodule
